// File: rtl/vending_pkg.sv
// Shared types and constants for the vending machine front end and its coin conditioner.
package vending_pkg;

    typedef enum logic [1:0] {
        COIN_NICKEL  = 2'd0,
        COIN_DIME    = 2'd1,
        COIN_QUARTER = 2'd2
    } coin_t;

    localparam int unsigned VALUE_NICKEL  = 5;
    localparam int unsigned VALUE_DIME    = 10;
    localparam int unsigned VALUE_QUARTER = 25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COIN   = 2'd1,
        REFUND = 2'd2
    } presenter_state_t;

    // One-hot presentation vector ordered {quarter, dime, nickel}.
    function automatic logic [2:0] coin_onehot(input coin_t c);
        logic [2:0] v;
        v = 3'b000;
        case (c)
            COIN_NICKEL:  v = 3'b001;
            COIN_DIME:    v = 3'b010;
            COIN_QUARTER: v = 3'b100;
            default:      v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coin_debouncer.sv
// Two-flop synchronizer plus stability-count debouncer; emits a one-cycle pulse on each
// accepted rising level change, registered together with the debounced state update.
module coin_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_state;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                // This sample is the DEBOUNCE_CYCLES-th consecutive differing one.
                r_state <= r_sync2;
                r_cnt   <= '0;
                r_rise  <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/coin_input_conditioner.sv
// Debounces coin/refund inputs, queues coins and presents each one (or a refund)
// as a level held for one CPU polling window.
module coin_input_conditioner
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic nickel_raw,
    input  logic dime_raw,
    input  logic quarter_raw,
    input  logic refund_raw,
    output logic nickel,
    output logic dime,
    output logic quarter,
    output logic refund,
    output logic busy,
    output logic overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic [3:0]       w_raw;
    logic [3:0]       w_ev;
    logic [2:0]       w_drain;
    logic             w_push;
    coin_t            w_push_coin;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_go_refund;

    logic [2:0]       r_pend;
    logic             r_refund_pend;
    logic             r_overflow;
    logic             r_busy;
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    coin_t            r_fifo [FIFO_DEPTH];
    presenter_state_t r_state;
    logic [HW-1:0]    r_hold;
    logic [2:0]       r_coin_oh;
    logic             r_refund;

    assign w_raw = {refund_raw, quarter_raw, dime_raw, nickel_raw};

    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [3:0] (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (w_raw),
        .o_rise (w_ev)
    );

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Fixed-priority arbiter: quarter > dime > nickel, one coin per cycle.
    always_comb begin
        w_drain     = 3'b000;
        w_push      = 1'b0;
        w_push_coin = COIN_NICKEL;
        if (!w_full) begin
            if (r_pend[COIN_QUARTER]) begin
                w_drain[COIN_QUARTER] = 1'b1;
                w_push      = 1'b1;
                w_push_coin = COIN_QUARTER;
            end else if (r_pend[COIN_DIME]) begin
                w_drain[COIN_DIME] = 1'b1;
                w_push      = 1'b1;
                w_push_coin = COIN_DIME;
            end else if (r_pend[COIN_NICKEL]) begin
                w_drain[COIN_NICKEL] = 1'b1;
                w_push      = 1'b1;
                w_push_coin = COIN_NICKEL;
            end
        end
    end

    assign w_pop       = (r_state == IDLE) && !w_empty;
    assign w_go_refund = (r_state == IDLE) && w_empty && (r_pend == 3'b000) && r_refund_pend;

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= w_push_coin;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend        <= 3'b000;
            r_refund_pend <= 1'b0;
            r_overflow    <= 1'b0;
            r_busy        <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_state       <= IDLE;
            r_hold        <= '0;
            r_coin_oh     <= 3'b000;
            r_refund      <= 1'b0;
        end else begin
            // A same-cycle event on a draining bit re-arms it rather than overflowing.
            r_pend        <= w_ev[2:0] | (r_pend & ~w_drain);
            r_overflow    <= |(w_ev[2:0] & r_pend & ~w_drain);
            r_refund_pend <= w_ev[3] | (r_refund_pend & ~w_go_refund);
            r_busy        <= (r_state != IDLE) || !w_empty || (r_pend != 3'b000) || r_refund_pend;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state   <= COIN;
                        r_hold    <= HOLD_LOAD;
                        r_coin_oh <= coin_onehot(r_fifo[r_rd_ptr[AW-1:0]]);
                    end else if (w_go_refund) begin
                        r_state  <= REFUND;
                        r_hold   <= HOLD_LOAD;
                        r_refund <= 1'b1;
                    end
                end
                COIN, REFUND: begin
                    if (r_hold == '0) begin
                        r_state   <= IDLE;
                        r_coin_oh <= 3'b000;
                        r_refund  <= 1'b0;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_coin_oh <= 3'b000;
                    r_refund  <= 1'b0;
                end
            endcase
        end
    end

    assign nickel   = r_coin_oh[0];
    assign dime     = r_coin_oh[1];
    assign quarter  = r_coin_oh[2];
    assign refund   = r_refund;
    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Scoreboard bench: expected presentation windows are queued as stimulus is driven and
// matched against each window the DUT produces (type, length, gap).
module tb_coin_input_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic nickel_raw = 1'b0, dime_raw = 1'b0, quarter_raw = 1'b0, refund_raw = 1'b0;
    logic nickel, dime, quarter, refund, busy, overflow;

    always #5 clk = ~clk;

    coin_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (16),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .nickel_raw  (nickel_raw),
        .dime_raw    (dime_raw),
        .quarter_raw (quarter_raw),
        .refund_raw  (refund_raw),
        .nickel      (nickel),
        .dime        (dime),
        .quarter     (quarter),
        .refund      (refund),
        .busy        (busy),
        .overflow    (overflow)
    );

    // Window vector {refund, quarter, dime, nickel}; gap = idle cycles before it, -1 = don't care.
    typedef struct {
        logic [3:0] vec;
        int         gap;
    } exp_t;

    localparam logic [3:0] N = 4'b0001, D = 4'b0010, Q = 4'b0100, R = 4'b1000;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    logic [3:0] mvec;
    assign mvec = {refund, quarter, dime, nickel};

    logic [3:0] m_prev = 4'b0;
    int   m_len = 0, m_gap = 0, m_start_gap = -1, m_ovf = 0, m_win = 0;
    logic m_gap_valid = 1'b0;
    exp_t m_e;

    always @(negedge clk) begin
        if (overflow) m_ovf++;
        if (reset) begin
            m_prev      = 4'b0;
            m_len       = 0;
            m_gap       = 0;
            m_gap_valid = 1'b0;
        end else begin
            if (mvec != 4'b0 && m_prev == 4'b0) begin
                m_start_gap = m_gap_valid ? m_gap : -1;
                m_len = 1;
                m_win++;
                chk("onehot", 32'($onehot(mvec)), 32'd1);
            end else if (mvec != 4'b0) begin
                m_len++;
                if (mvec != m_prev) chk("stable", 32'(mvec), 32'(m_prev));
            end else if (m_prev != 4'b0) begin
                if (sb.size() == 0) begin
                    chk("unexpected window", 32'(m_prev), 32'd0);
                end else begin
                    m_e = sb.pop_front();
                    chk("window type", 32'(m_prev), 32'(m_e.vec));
                    chk("hold length", 32'(m_len), 32'd16);
                    if (m_e.gap >= 0) chk("idle gap", 32'(m_start_gap), 32'(m_e.gap));
                end
                m_gap = 1;
                m_gap_valid = 1'b1;
            end else begin
                m_gap++;
            end
            m_prev = mvec;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_raw(input logic [3:0] v);
        {refund_raw, quarter_raw, dime_raw, nickel_raw} = v;
    endtask

    task automatic pulse(input logic [3:0] v, input int hi, input int lo);
        set_raw(v);
        tick(hi);
        set_raw(4'b0);
        tick(lo);
    endtask

    task automatic push(input logic [3:0] v, input int gap);
        exp_t e;
        e.vec = v;
        e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k;
        for (k = 0; k < max; k++) begin
            if (sb.size() == 0 && !busy && mvec == 4'b0) break;
            tick(1);
        end
        chk({tag, " drained"}, 32'(k < max), 32'd1);
    endtask

    task automatic wait_out(input string tag, input int idx, input int max);
        int k;
        for (k = 0; k < max; k++) begin
            if (mvec[idx]) break;
            tick(1);
        end
        chk({tag, " seen"}, 32'(k < max), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, ov0, w0;
        set_raw(4'b0);
        tick(3);
        chk("reset outputs", 32'({mvec, busy, overflow}), 32'd0);
        reset = 1'b0;
        tick(5);

        // Clean 10-cycle nickel: latency and single window, no overflow
        ov0 = m_ovf;
        push(N, -1);
        set_raw(N);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (nickel && lat == 0) lat = k;
        end
        set_raw(4'b0);
        chk("nickel latency", 32'(lat), 32'd9);
        tick(3);
        chk("busy presenting", 32'(busy), 32'd1);
        wait_idle("nickel", 200);
        chk("nickel overflow", 32'(m_ovf - ov0), 32'd0);

        // Bouncing quarter then stable high: one window
        push(Q, -1);
        for (int i = 0; i < 6; i++) begin
            set_raw((i % 2 == 0) ? Q : 4'b0);
            tick(1);
        end
        pulse(Q, 8, 4);
        tick(8);
        wait_idle("bounce", 200);

        // Simultaneous coins: quarter, dime, nickel with one idle cycle between
        push(Q, -1);
        push(D, 1);
        push(N, 1);
        pulse(N | D | Q, 6, 6);
        wait_idle("simultaneous", 300);

        // Refund during dime with nickel queued: refund comes last
        push(D, -1);
        push(N, 1);
        push(R, 1);
        pulse(N | D, 6, 0);
        wait_out("dime", 1, 40);
        tick(3);
        pulse(R, 6, 6);
        wait_idle("refund", 300);

        // Three back-to-back bursts fill the FIFO; third nickel hits a pending nickel
        ov0 = m_ovf;
        push(Q, -1);
        push(D, 1);
        push(N, 1);
        push(Q, 1);
        push(D, 1);
        push(Q, 1);
        push(D, 1);
        push(N, 1);
        repeat (3) pulse(N | D | Q, 4, 4);
        wait_idle("overflow", 400);
        chk("overflow pulses", 32'(m_ovf - ov0), 32'd1);

        // Reset mid-presentation with coins queued drops everything
        set_raw(N | D | Q);
        tick(6);
        set_raw(4'b0);
        wait_out("quarter", 2, 40);
        tick(7);
        #2 reset = 1'b1;
        #1;
        chk("reset mid outputs", 32'({mvec, overflow}), 32'd0);
        chk("reset mid busy", 32'(busy), 32'd0);
        tick(3);
        reset = 1'b0;
        w0 = m_win;
        tick(80);
        chk("no windows after reset", 32'(m_win - w0), 32'd0);
        chk("idle after reset", 32'({busy, mvec}), 32'd0);
        chk("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
